// File: rtl/rpsc_pkg.sv
// Shared types and the outcome function for the rock-paper-scissors round sequencer.
package rpsc_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    ILLEGAL  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    TIE     = 2'b00,
    P1_WINS = 2'b01,
    P2_WINS = 2'b10,
    VOID    = 2'b11
  } outcome_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    CAPTURE   = 2'b10,
    RESULT    = 2'b11
  } phase_t;

  // A lone thrower wins by default; nobody throwing voids the round.
  function automatic outcome_t winner(input logic p1_got, input move_t p1,
                                      input logic p2_got, input move_t p2);
    outcome_t res;
    if (p1_got && p2_got) begin
      if (p1 == p2)
        res = TIE;
      else if ((p1 == PAPER    && p2 == ROCK)     ||
               (p1 == SCISSORS && p2 == PAPER)    ||
               (p1 == ROCK     && p2 == SCISSORS))
        res = P1_WINS;
      else
        res = P2_WINS;
    end else if (p1_got) begin
      res = P1_WINS;
    end else if (p2_got) begin
      res = P2_WINS;
    end else begin
      res = VOID;
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counter that flags its terminal value and wraps back to zero there,
// so consecutive beats/phases chain without an extra idle cycle.
module phase_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  assign expire = (count == limit);

  // Count up, restarting at zero on clear or after the terminal cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear || expire)
      count <= '0;
    else
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/round_sequencer.sv
// Rock-paper-scissors round sequencer: 3-beat countdown, move capture window,
// then a held result. All outputs come straight from flops.
// Note: the default RESULT_T does not fit a 16-bit counter; raise WIDTH when
// using timings at or above 2**WIDTH.
module round_sequencer
  import rpsc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BEAT_T    = 50000,
  parameter int CAPTURE_T = 25000,
  parameter int RESULT_T  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       p1_valid,
  input  logic       p2_valid,
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] state,
  output logic [1:0] beat,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [WIDTH-1:0] BEAT_LIM    = WIDTH'(BEAT_T - 1);
  localparam logic [WIDTH-1:0] CAPTURE_LIM = WIDTH'(CAPTURE_T - 1);
  localparam logic [WIDTH-1:0] RESULT_LIM  = WIDTH'(RESULT_T - 1);

  phase_t           phase, phase_next;
  logic [WIDTH-1:0] limit;
  logic             expire;
  logic             timer_clear;
  logic             p1_got, p2_got;
  move_t            p1_mv, p2_mv;
  logic             p1_take, p2_take;
  outcome_t         verdict;
  logic [1:0]       beat_next;
  logic [1:0]       result_next;
  logic             done_next;

  // Timer idles at zero in IDLE so a new round always starts from count 0
  assign timer_clear = (phase == IDLE) || abort;

  // Pick the terminal count for the phase currently running
  always_comb begin
    limit = BEAT_LIM;
    case (phase)
      CAPTURE: limit = CAPTURE_LIM;
      RESULT:  limit = RESULT_LIM;
      default: limit = BEAT_LIM;
    endcase
  end

  phase_timer #(.WIDTH(WIDTH)) timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .limit  (limit),
    .expire (expire)
  );

  assign p1_take = (phase == CAPTURE) && p1_valid && (p1_move != 2'b11) && !p1_got;
  assign p2_take = (phase == CAPTURE) && p2_valid && (p2_move != 2'b11) && !p2_got;

  // The expiry cycle's own strobes count, so fold this cycle's takes in
  assign verdict = winner(p1_got | p1_take, p1_take ? move_t'(p1_move) : p1_mv,
                          p2_got | p2_take, p2_take ? move_t'(p2_move) : p2_mv);

  // Keep the first legal move per player; forget everything outside CAPTURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_got <= 1'b0;
      p2_got <= 1'b0;
      p1_mv  <= ROCK;
      p2_mv  <= ROCK;
    end else if (abort || phase != CAPTURE) begin
      p1_got <= 1'b0;
      p2_got <= 1'b0;
      p1_mv  <= ROCK;
      p2_mv  <= ROCK;
    end else begin
      if (p1_take) begin
        p1_got <= 1'b1;
        p1_mv  <= move_t'(p1_move);
      end
      if (p2_take) begin
        p2_got <= 1'b1;
        p2_mv  <= move_t'(p2_move);
      end
    end
  end

  // Phase register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      phase <= IDLE;
    else
      phase <= phase_next;
  end

  // Phase transitions; abort overrides everything, including a same-cycle start
  always_comb begin
    phase_next = phase;
    if (abort) begin
      phase_next = IDLE;
    end else begin
      case (phase)
        IDLE:      if (start) phase_next = COUNTDOWN;
        COUNTDOWN: if (expire && beat == 2'd1) phase_next = CAPTURE;
        CAPTURE:   if (expire) phase_next = RESULT;
        RESULT:    if (expire) phase_next = IDLE;
        default:   phase_next = IDLE;
      endcase
    end
  end

  // Next values for the registered outputs
  always_comb begin
    beat_next   = 2'd0;
    result_next = result;
    done_next   = 1'b0;
    if (!abort) begin
      case (phase)
        IDLE:    if (start)  result_next = TIE;
        CAPTURE: if (expire) result_next = verdict;
        RESULT:  if (expire) done_next   = 1'b1;
        default: ;
      endcase
    end
    if (phase_next == COUNTDOWN) begin
      if (phase != COUNTDOWN)
        beat_next = 2'd3;
      else if (expire)
        beat_next = beat - 2'd1;
      else
        beat_next = beat;
    end
  end

  // Output flops, so nothing combinational reaches a port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat         <= 2'd0;
      result       <= 2'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      beat         <= beat_next;
      result       <= result_next;
      result_valid <= (phase_next == RESULT);
      busy         <= (phase_next != IDLE);
      done         <= done_next;
    end
  end

  assign state = phase;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with short timings (4/6/5 cycles).
module tb_round_sequencer;

  localparam int WIDTH     = 16;
  localparam int BEAT_T    = 4;
  localparam int CAPTURE_T = 6;
  localparam int RESULT_T  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       p1_valid = 1'b0;
  logic       p2_valid = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic [1:0] p2_move = 2'b00;
  logic [1:0] state;
  logic [1:0] beat;
  logic [1:0] result;
  logic       result_valid;
  logic       busy;
  logic       done;

  typedef struct {
    logic [1:0] res;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   fails = 0;
  logic rv_prev = 1'b0;
  int   rv_len = 0;
  int   done_seen;

  round_sequencer #(
    .WIDTH     (WIDTH),
    .BEAT_T    (BEAT_T),
    .CAPTURE_T (CAPTURE_T),
    .RESULT_T  (RESULT_T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .p1_valid     (p1_valid),
    .p2_valid     (p2_valid),
    .p1_move      (p1_move),
    .p2_move      (p2_move),
    .state        (state),
    .beat         (beat),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One full round. Cycle c = c-th cycle after the start edge; moves driven in
  // cycle c are sampled on the edge that ends it. CAPTURE spans cycles 13..18.
  task automatic applyStimulus(input int p1a_c, input logic [1:0] p1a_m,
                               input int p1b_c, input logic [1:0] p1b_m,
                               input int p2a_c, input logic [1:0] p2a_m,
                               input int p2b_c, input logic [1:0] p2b_m,
                               input logic [1:0] exp_res, input bit trace,
                               input bit chain);
    exp_t e;
    int   exp_state;
    int   exp_beat;
    e.res = exp_res;
    e.len = RESULT_T;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 24; c++) begin
      if (trace) begin
        if (c <= 12) begin
          exp_state = 1;
          exp_beat  = 3 - (c - 1) / 4;
        end else if (c <= 18) begin
          exp_state = 2;
          exp_beat  = 0;
        end else if (c <= 23) begin
          exp_state = 3;
          exp_beat  = 0;
        end else begin
          exp_state = 0;
          exp_beat  = 0;
        end
        checkOutput("trace_state", state, exp_state);
        checkOutput("trace_beat", beat, exp_beat);
        checkOutput("trace_busy", busy, (exp_state != 0) ? 1 : 0);
      end
      if (c == 24) checkOutput("done_pulse", done, 1);
      start    = (trace && c == 10) || (chain && c == 24);
      p1_valid = (c == p1a_c) || (c == p1b_c);
      p1_move  = (c == p1b_c) ? p1b_m : p1a_m;
      p2_valid = (c == p2a_c) || (c == p2b_c);
      p2_move  = (c == p2b_c) ? p2b_m : p2a_m;
      @(negedge clk);
    end
    start    = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    if (!chain) checkOutput("done_clear", done, 0);
  endtask

  // Monitor: pop an expectation when a result appears, then check how long it is held
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      rv_len = 0;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        cur.res = 2'b00;
        cur.len = 0;
        $display("[TB] FAIL unexpected_result: got %0d, expected no result", result);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("result_value", result, cur.res);
      end
    end
    if (result_valid)
      rv_len++;
    else if (rv_prev)
      checkOutput("result_valid_len", rv_len, cur.len);
    rv_prev = result_valid;
  end

  // Watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    #12;
    checkOutput("reset_state", {state, beat, result, result_valid, busy, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // No moves at all, full phase/beat trace, stray start in COUNTDOWN
    applyStimulus(0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'b11, 1'b1, 1'b0);
    // p1 rock first capture cycle, p2 scissors on the expiry cycle
    applyStimulus(13, 2'd0, 0, 2'd0, 18, 2'd2, 0, 2'd0, 2'b01, 1'b0, 1'b0);
    // p1 paper then scissors (second ignored), p2 paper -> tie
    applyStimulus(13, 2'd1, 15, 2'd2, 14, 2'd1, 0, 2'd0, 2'b00, 1'b0, 1'b0);
    // p2 only presents the illegal code, p1 rock -> p1 wins
    applyStimulus(16, 2'd0, 0, 2'd0, 14, 2'd3, 0, 2'd0, 2'b01, 1'b0, 1'b0);
    // Throws only during COUNTDOWN (including its last cycle) -> void
    applyStimulus(5, 2'd0, 0, 2'd0, 12, 2'd1, 0, 2'd0, 2'b11, 1'b0, 1'b0);
    // p1 scissors vs p2 rock -> p2 wins
    applyStimulus(13, 2'd2, 0, 2'd0, 17, 2'd0, 0, 2'd0, 2'b10, 1'b0, 1'b0);
    // Only p2 throws, on the expiry cycle -> p2 wins
    applyStimulus(0, 2'd0, 0, 2'd0, 18, 2'd1, 0, 2'd0, 2'b10, 1'b0, 1'b0);
    // Paper vs rock, then start during the done cycle
    applyStimulus(13, 2'd1, 0, 2'd0, 13, 2'd0, 0, 2'd0, 2'b01, 1'b0, 1'b1);
    checkOutput("chain_state", state, 1);
    checkOutput("chain_beat", beat, 3);
    checkOutput("chain_result_cleared", result, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_countdown_state", state, 0);
    checkOutput("abort_countdown_beat", beat, 0);

    // Abort in CAPTURE cycle 3 after p1 has thrown
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      p1_valid = (c == 13);
      p1_move  = 2'd1;
      @(negedge clk);
    end
    p1_valid = 1'b0;
    checkOutput("pre_abort_state", state, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_state", state, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", result, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || result_valid) done_seen++;
      @(negedge clk);
    end
    checkOutput("no_done_after_abort", done_seen, 0);

    // start and abort together keep IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_state", state, 0);
    checkOutput("start_abort_busy", busy, 0);

    // Reset in the third RESULT cycle
    cur.res = 2'b01;
    cur.len = 3;
    exp_q.push_back(cur);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      p1_valid = (c == 13);
      p1_move  = 2'd1;
      p2_valid = (c == 14);
      p2_move  = 2'd0;
      @(negedge clk);
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {state, beat, result, result_valid, busy, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", {state, busy, done}, 0);

    // Full round after reset: p1 scissors vs p2 paper
    applyStimulus(14, 2'd2, 0, 2'd0, 15, 2'd1, 0, 2'd0, 2'b01, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the internal phase counter.
REQ-002 SHALL have parameter BEAT_T, default 50000, cycles per countdown beat (legal range 2..2^WIDTH-1).
REQ-003 SHALL have parameter CAPTURE_T, default 25000, cycles in the move-capture window (legal range 2..2^WIDTH-1).
REQ-004 SHALL have parameter RESULT_T, default 100000, cycles the result is held (legal range 2..2^WIDTH-1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request a new round; sampled only in IDLE.
REQ-008 SHALL have port abort  input  1  return to IDLE from any state.
REQ-009 SHALL have ports p1_valid, p2_valid  input  1 each  move strobes.
REQ-010 SHALL have ports p1_move, p2_move  input  2 each  move codes: 00 rock, 01 paper, 10 scissors, 11 illegal.
REQ-011 SHALL have port state  output  2  current phase: 00 IDLE, 01 COUNTDOWN, 10 CAPTURE, 11 RESULT.
REQ-012 SHALL have port beat  output  2  remaining countdown beat (3,2,1); 0 outside COUNTDOWN.
REQ-013 SHALL have port result  output  2  outcome: 00 tie, 01 p1 wins, 10 p2 wins, 11 void.
REQ-014 SHALL have port result_valid  output  1  high exactly while state is RESULT.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse in the first IDLE cycle after RESULT expires.

Function
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 IDLE with start=1 and abort=0 at an edge SHALL enter COUNTDOWN with beat=3 and clear result to 00.
REQ-019 Each phase counter SHALL clear on phase entry and on each beat change, and expire when count == T-1, so every beat and phase lasts exactly its T cycles.
REQ-020 COUNTDOWN SHALL decrement beat on each beat expiry, and on expiry of beat 1 SHALL enter CAPTURE; COUNTDOWN lasts 3*BEAT_T cycles total.
REQ-021 Moves presented outside CAPTURE SHALL be ignored (early throws discarded).
REQ-022 In CAPTURE, the first valid strobe per player with a legal code SHALL be latched; later strobes and code 11 SHALL be ignored; the expiry cycle itself is sampled.
REQ-023 On CAPTURE expiry the sequencer SHALL enter RESULT with: both latched -> standard rock-paper-scissors outcome (equal codes = tie); only one latched -> that player wins; none -> void (11).
REQ-024 RESULT SHALL last RESULT_T cycles, then enter IDLE, pulsing done for that first IDLE cycle.
REQ-025 result SHALL hold its value in IDLE until the next accepted start.
REQ-026 abort=1 SHALL force IDLE at the next edge from any state, clear latched moves and beat, suppress done, and leave result unchanged.
REQ-027 abort and start asserted together in IDLE SHALL keep the sequencer in IDLE.
REQ-028 start asserted during the done cycle SHALL be accepted; start in non-IDLE states SHALL be ignored.

Reset
REQ-029 Asserting reset (low) SHALL asynchronously force state=IDLE, beat=0, result=00, result_valid=0, busy=0, done=0, counter=0, latched moves cleared.
REQ-030 Reset mid-round SHALL abandon the round without a done pulse; operation resumes on the first edge after reset deasserts.

Structure
REQ-031 Package rpsc_pkg SHALL hold move_t, outcome_t, and the phase_t enum, plus the winner function.
REQ-032 Sub-module phase_timer (WIDTH, load/clear, terminal count T-1, expire pulse, async active-low reset) SHALL implement the counter.

Verification (BEAT_T=4, CAPTURE_T=6, RESULT_T=5)
REQ-033 start pulse -> COUNTDOWN for 12 cycles with beat 3,3,3,3,2,...,1; CAPTURE 6 cycles; RESULT 5 cycles; done high in the 24th cycle after start.
REQ-034 p1 rock at CAPTURE cycle 1, p2 scissors at cycle 6 -> result=01, result_valid high for 5 cycles.
REQ-035 p1 paper then p1 scissors, p2 paper -> result=00 (first move kept); p2 code 11 only -> result=01.
REQ-036 no valid moves, or moves during COUNTDOWN only -> result=11.
REQ-037 abort in CAPTURE cycle 3 -> IDLE next cycle, busy=0, no done; start with abort together -> stays IDLE.
REQ-038 reset low mid-RESULT -> all outputs zero immediately (before next edge); start after release runs a full round.
